// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network datapath blocks.
// Provides default widths, the rate word type and a saturating increment helper.
package snn_pkg;

  localparam int unsigned CntWDef = 8;   // spike count / rate width
  localparam int unsigned WinWDef = 16;  // window length / timer width

  typedef logic [CntWDef-1:0] rate_t;

  // Increment val, clamping at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (32'd1 << width) - 32'd1;
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/window_timer.sv
// Window timer: counts enabled cycles and pulses close_o in the last enabled cycle of each window.
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   en_i         advance enable; timer holds when low
//   window_len_i window length in enabled cycles (0 behaves as 1), latched at window start
//   close_o      high in the close cycle (en_i=1 and timer at L-1)
module window_timer import snn_pkg::*; #(
  parameter int unsigned WIN_W = WinWDef
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIN_W-1:0] window_len_i,
  output logic             close_o
);

  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [WIN_W-1:0] len_q, len_d;
  logic             start_q, start_d;
  logic [WIN_W-1:0] eff_len;
  logic [WIN_W-1:0] last_cnt;

  // In the first cycle of a window the length comes straight from the input, so a
  // window can also close in that cycle (L of 0 or 1).
  assign eff_len  = start_q ? window_len_i : len_q;
  assign last_cnt = (eff_len == '0) ? '0 : eff_len - WIN_W'(1);
  assign close_o  = en_i && (win_cnt_q == last_cnt);

  always_comb begin
    len_d     = start_q ? window_len_i : len_q;
    start_d   = close_o;
    win_cnt_d = win_cnt_q;
    if (close_o) begin
      win_cnt_d = '0;
    end else if (en_i) begin
      win_cnt_d = win_cnt_q + WIN_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      win_cnt_q <= '0;
      len_q     <= '0;
      start_q   <= 1'b1;
    end else begin
      win_cnt_q <= win_cnt_d;
      len_q     <= len_d;
      start_q   <= start_d;
    end
  end

endmodule

// File: rtl/spike_rate_encoder.sv
// Spike rate encoder: counts spikes over fixed windows of enabled cycles and presents each
// window's count on a valid/ready output, flagging counts lost to back-pressure.
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   en_i           advance enable; timer and spike count freeze when low
//   spike_i        spike pulse, counted once per enabled cycle it is high
//   window_len_i   window length L in enabled cycles (0 treated as 1)
//   rate_o         spike count of the most recently loaded window
//   rate_valid_o   rate_o holds an unconsumed value
//   rate_ready_i   consumer accepts rate_o when rate_valid_o && rate_ready_i
//   window_tick_o  one-cycle pulse on the edge after each window close
//   overrun_o      sticky: a window closed while the previous rate was pending
//   clr_overrun_i  clears overrun_o (a simultaneous overrun event wins)
module spike_rate_encoder import snn_pkg::*; #(
  parameter int unsigned CNT_W = CntWDef,
  parameter int unsigned WIN_W = WinWDef
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             spike_i,
  input  logic [WIN_W-1:0] window_len_i,
  output logic [CNT_W-1:0] rate_o,
  output logic             rate_valid_o,
  input  logic             rate_ready_i,
  output logic             window_tick_o,
  output logic             overrun_o,
  input  logic             clr_overrun_i
);

  logic             close;
  logic [CNT_W-1:0] spk_cnt_q, spk_cnt_d;
  logic [CNT_W-1:0] rate_q, rate_d;
  logic             valid_q, valid_d;
  logic             tick_q, tick_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] spk_inc;
  logic [CNT_W-1:0] count_final;
  logic             accept;
  logic             ovf_evt;

  window_timer #(
    .WIN_W (WIN_W)
  ) u_window_timer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .window_len_i (window_len_i),
    .close_o      (close)
  );

  assign spk_inc     = CNT_W'(sat_inc(32'(spk_cnt_q), CNT_W));
  // Close-cycle spike belongs to the closing window.
  assign count_final = (en_i && spike_i) ? spk_inc : spk_cnt_q;
  assign accept      = valid_q && rate_ready_i;
  assign ovf_evt     = close && valid_q && !rate_ready_i;

  always_comb begin
    spk_cnt_d = spk_cnt_q;
    rate_d    = rate_q;
    valid_d   = valid_q;
    tick_d    = close;
    overrun_d = overrun_q;

    if (close) begin
      spk_cnt_d = '0;
      // Slot is free if empty or being drained this cycle; otherwise the new count is dropped.
      if (!valid_q || rate_ready_i) begin
        rate_d  = count_final;
        valid_d = 1'b1;
      end
    end else begin
      if (en_i && spike_i) begin
        spk_cnt_d = spk_inc;
      end
      if (accept) begin
        valid_d = 1'b0;
      end
    end

    if (ovf_evt) begin
      overrun_d = 1'b1;
    end else if (clr_overrun_i) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      spk_cnt_q <= '0;
      rate_q    <= '0;
      valid_q   <= 1'b0;
      tick_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      spk_cnt_q <= spk_cnt_d;
      rate_q    <= rate_d;
      valid_q   <= valid_d;
      tick_q    <= tick_d;
      overrun_q <= overrun_d;
    end
  end

  assign rate_o        = rate_q;
  assign rate_valid_o  = valid_q;
  assign window_tick_o = tick_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder: an 8-bit-count instance for most checks and a
// 4-bit-count instance (same stimulus) for the saturation check.
module tb_spike_rate_encoder;
  import snn_pkg::*;

  logic        clk;
  logic        rst;
  logic        en;
  logic        spike;
  logic [15:0] window_len;
  logic        rate_ready;
  logic        clr_overrun;

  rate_t       rate8;
  logic        valid8, tick8, ovr8;
  logic [3:0]  rate4;
  logic        valid4, tick4, ovr4;

  int n_cmp;
  int n_bad;

  spike_rate_encoder #(
    .CNT_W (8),
    .WIN_W (16)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .en_i          (en),
    .spike_i       (spike),
    .window_len_i  (window_len),
    .rate_o        (rate8),
    .rate_valid_o  (valid8),
    .rate_ready_i  (rate_ready),
    .window_tick_o (tick8),
    .overrun_o     (ovr8),
    .clr_overrun_i (clr_overrun)
  );

  spike_rate_encoder #(
    .CNT_W (4),
    .WIN_W (16)
  ) dut4 (
    .clk_i         (clk),
    .rst_i         (rst),
    .en_i          (en),
    .spike_i       (spike),
    .window_len_i  (window_len),
    .rate_o        (rate4),
    .rate_valid_o  (valid4),
    .rate_ready_i  (rate_ready),
    .window_tick_o (tick4),
    .overrun_o     (ovr4),
    .clr_overrun_i (clr_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are stable #1 after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [3:0] pat;

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    rst         = 1'b1;
    en          = 1'b0;
    spike       = 1'b0;
    window_len  = 16'd4;
    rate_ready  = 1'b0;
    clr_overrun = 1'b0;

    // Reset state
    do_reset();
    check_eq("rst_rate", rate8, 0);
    check_eq("rst_valid", valid8, 0);
    check_eq("rst_tick", tick8, 0);
    check_eq("rst_overrun", ovr8, 0);

    // L=4, constant spikes, always ready: rate=4 for one cycle every 4
    window_len = 16'd4; en = 1'b1; spike = 1'b1; rate_ready = 1'b1;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 3; i++) begin
        step();
        check_eq("l4_idle_valid", valid8, 0);
        check_eq("l4_idle_tick", tick8, 0);
      end
      step();
      check_eq("l4_valid", valid8, 1);
      check_eq("l4_rate", rate8, 4);
      check_eq("l4_tick", tick8, 1);
    end

    // L=20, spikes always high: 4-bit counter saturates at 15
    do_reset();
    window_len = 16'd20; en = 1'b1; spike = 1'b1; rate_ready = 1'b1;
    for (int i = 0; i < 19; i++) step();
    check_eq("sat_pre_valid", valid4, 0);
    step();
    check_eq("sat_valid", valid4, 1);
    check_eq("sat_rate4", rate4, 15);
    check_eq("sat_rate8", rate8, 20);

    // Back-pressure: window 1 = 2 spikes, window 2 = 3 spikes, ready low
    do_reset();
    window_len = 16'd4; en = 1'b1; rate_ready = 1'b0;
    pat = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      spike = pat[i];
      step();
    end
    check_eq("bp_w1_valid", valid8, 1);
    check_eq("bp_w1_rate", rate8, 2);
    check_eq("bp_w1_ovr", ovr8, 0);
    pat = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      spike = pat[i];
      step();
    end
    check_eq("bp_w2_rate", rate8, 2);
    check_eq("bp_w2_valid", valid8, 1);
    check_eq("bp_w2_ovr", ovr8, 1);
    check_eq("bp_w2_tick", tick8, 1);
    en = 1'b0; spike = 1'b1;
    step();
    step();
    check_eq("bp_hold_ovr", ovr8, 1);
    check_eq("bp_hold_rate", rate8, 2);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    check_eq("bp_clr_ovr", ovr8, 0);
    rate_ready = 1'b1;
    step();
    check_eq("bp_drain_valid", valid8, 0);
    check_eq("bp_drain_rate", rate8, 2);

    // Close coincides with handshake: old taken, new loaded, no overrun
    do_reset();
    window_len = 16'd4; en = 1'b1; spike = 1'b1; rate_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_eq("co_w1_rate", rate8, 4);
    pat = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      spike      = pat[i];
      rate_ready = (i == 3);
      step();
    end
    rate_ready = 1'b0;
    check_eq("co_rate", rate8, 2);
    check_eq("co_valid", valid8, 1);
    check_eq("co_ovr", ovr8, 0);
    check_eq("co_tick", tick8, 1);

    // L=8, en toggling, spike always high: 8th enabled cycle closes
    do_reset();
    window_len = 16'd8; spike = 1'b1; rate_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      en = ((i % 2) == 0);
      step();
      if (i == 13) check_eq("en_pre_valid", valid8, 0);
      if (i == 14) begin
        check_eq("en_valid", valid8, 1);
        check_eq("en_tick", tick8, 1);
      end
    end
    check_eq("en_rate", rate8, 8);

    // Reset mid-window discards partial count and pending rate
    window_len = 16'd8; en = 1'b1; spike = 1'b1;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    step();
    check_eq("mid_rst_valid", valid8, 0);
    check_eq("mid_rst_ovr", ovr8, 0);
    check_eq("mid_rst_rate", rate8, 0);
    rst = 1'b0;
    window_len = 16'd4; rate_ready = 1'b1;
    pat = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      spike = pat[i];
      step();
    end
    check_eq("mid_rate", rate8, 1);
    check_eq("mid_valid", valid8, 1);

    // L=0 behaves as L=1: every enabled cycle closes
    do_reset();
    window_len = 16'd0; en = 1'b1; spike = 1'b1; rate_ready = 1'b1;
    step();
    check_eq("l0_valid", valid8, 1);
    check_eq("l0_rate1", rate8, 1);
    spike = 1'b0;
    step();
    check_eq("l0_rate0", rate8, 0);
    check_eq("l0_tick", tick8, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
